// File: rtl/color_label_writer_pkg.sv
// Shared definitions for the label frame buffer: geometry, address width and label codes.
// Also consumed by the playback stage's colour decode, so keep label encodings stable.
package color_label_writer_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int ADDR_W       = 19;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;

  typedef enum logic [2:0] {
    LBL_NONE    = 3'd0,
    LBL_RED     = 3'd1,
    LBL_GREEN   = 3'd2,
    LBL_BLUE    = 3'd3,
    LBL_MAGENTA = 3'd4,
    LBL_CYAN    = 3'd5,
    LBL_MARKER  = 3'd6,
    LBL_YELLOW  = 3'd7
  } label_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } wr_state_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/color_classifier.sv
// Combinational RGB444 -> colour label; zero latency, no flow control.
// A channel between CH_MAX_OFF and CH_MIN is ambiguous and forces LBL_NONE.
module color_classifier
  import color_label_writer_pkg::*;
#(
  parameter logic [3:0] CH_MIN     = 4'd8,
  parameter logic [3:0] CH_MAX_OFF = 4'd5
) (
  input  rgb444_t rgb,
  output label_e  label
);

  logic [2:0] ch_on;
  logic [2:0] ch_off;

  always_comb begin
    ch_on  = {rgb.r >= CH_MIN, rgb.g >= CH_MIN, rgb.b >= CH_MIN};
    ch_off = {rgb.r <= CH_MAX_OFF, rgb.g <= CH_MAX_OFF, rgb.b <= CH_MAX_OFF};
    label  = LBL_NONE;
    if ((ch_on | ch_off) == 3'b111) begin
      case (ch_on)
        3'b100:  label = LBL_RED;
        3'b010:  label = LBL_GREEN;
        3'b001:  label = LBL_BLUE;
        3'b101:  label = LBL_MAGENTA;
        3'b011:  label = LBL_CYAN;
        3'b110:  label = LBL_YELLOW;
        default: label = LBL_NONE;
      endcase
    end
  end

endmodule

// File: rtl/color_label_writer.sv
// Classifies the raster camera stream and writes one label per pixel to the label BRAM at y*H+x.
// Accepted pixel -> bram_we after exactly 3 cycles, one pixel per cycle; the BRAM never stalls.
module color_label_writer #(
  parameter int         H_ACTIVE   = color_label_writer_pkg::H_ACTIVE,
  parameter int         V_ACTIVE   = color_label_writer_pkg::V_ACTIVE,
  parameter logic [3:0] CH_MIN     = 4'd8,
  parameter logic [3:0] CH_MAX_OFF = 4'd5
) (
  input  logic                                     video_clk,
  input  logic                                     reset_n,
  input  logic                                     enable,
  input  logic                                     frame_start,
  input  logic                                     pixel_valid,
  input  logic [11:0]                              pixel_rgb,
  input  logic [color_label_writer_pkg::X_W-1:0]   marker_x,
  input  logic [color_label_writer_pkg::Y_W-1:0]   marker_y,
  output logic                                     bram_we,
  output logic [color_label_writer_pkg::ADDR_W-1:0] bram_addr,
  output logic [2:0]                               bram_din,
  output logic                                     frame_written,
  output logic                                     short_frame,
  output logic                                     overrun
);
  import color_label_writer_pkg::*;

  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_ACTIVE - 1);
  localparam logic [X_W-1:0]    X_LIMIT   = X_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  wr_state_e         state_q, state_d;
  logic [X_W-1:0]    x_q, cur_x;
  logic [Y_W-1:0]    y_q, cur_y;
  logic [ADDR_W-1:0] addr_q, cur_addr;
  logic              accept;
  logic              last_px;

  // A frame_start pixel is (0,0) of the new frame, so coordinates restart in the same cycle.
  always_comb begin
    cur_x    = frame_start ? '0 : x_q;
    cur_y    = frame_start ? '0 : y_q;
    cur_addr = frame_start ? '0 : addr_q;
    accept   = pixel_valid && (frame_start ? enable : (state_q == ST_ACTIVE));
    last_px  = (cur_x == X_LAST) && (cur_y == Y_LAST);
    state_d  = state_q;
    if (frame_start) begin
      state_d = enable ? ST_ACTIVE : ST_IDLE;
    end
    if (accept && last_px) begin
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge video_clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge video_clk) begin
    if (!reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else if (accept) begin
      if (cur_x == X_LAST) begin
        x_q <= '0;
        y_q <= last_px ? '0 : cur_y + Y_W'(1);
      end else begin
        x_q <= cur_x + X_W'(1);
        y_q <= cur_y;
      end
      addr_q <= last_px ? '0 : cur_addr + ADDR_W'(1);
    end else if (frame_start) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end
  end

  always_ff @(posedge video_clk) begin
    if (!reset_n) begin
      short_frame <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      short_frame <= frame_start && (state_q == ST_ACTIVE);
      if (pixel_valid && !frame_start && (state_q == ST_DONE)) begin
        overrun <= 1'b1;
      end
    end
  end

  logic              s1_vld;
  rgb444_t           s1_rgb;
  logic [X_W-1:0]    s1_x;
  logic [Y_W-1:0]    s1_y;
  logic [ADDR_W-1:0] s1_addr;
  label_e            s1_label;
  logic              s2_vld;
  label_e            s2_label;
  logic              s2_marker;
  logic [ADDR_W-1:0] s2_addr;

  always_ff @(posedge video_clk) begin
    if (!reset_n) begin
      s1_vld  <= 1'b0;
      s1_rgb  <= '0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_addr <= '0;
    end else begin
      s1_vld  <= accept;
      s1_rgb  <= rgb444_t'(pixel_rgb);
      s1_x    <= cur_x;
      s1_y    <= cur_y;
      s1_addr <= cur_addr;
    end
  end

  color_classifier #(
    .CH_MIN     (CH_MIN),
    .CH_MAX_OFF (CH_MAX_OFF)
  ) u_classifier (
    .rgb   (s1_rgb),
    .label (s1_label)
  );

  always_ff @(posedge video_clk) begin
    if (!reset_n) begin
      s2_vld    <= 1'b0;
      s2_label  <= LBL_NONE;
      s2_marker <= 1'b0;
      s2_addr   <= '0;
    end else begin
      s2_vld    <= s1_vld;
      s2_label  <= s1_label;
      s2_marker <= (marker_x < X_LIMIT) && ((s1_x == marker_x) || (s1_y == marker_y));
      s2_addr   <= s1_addr;
    end
  end

  // Address and data only move with a write so the BRAM port stays quiet between pixels.
  always_ff @(posedge video_clk) begin
    if (!reset_n) begin
      bram_we       <= 1'b0;
      bram_addr     <= '0;
      bram_din      <= '0;
      frame_written <= 1'b0;
    end else begin
      bram_we       <= s2_vld;
      frame_written <= s2_vld && (s2_addr == ADDR_LAST);
      if (s2_vld) begin
        bram_addr <= s2_addr;
        bram_din  <= s2_marker ? LBL_MARKER : s2_label;
      end
    end
  end

endmodule

// File: tb/tb_color_label_writer.sv
// Directed bench for color_label_writer on a 640x8 frame so whole frames stay short.
module tb_color_label_writer;

  localparam int TH   = 640;
  localparam int TV   = 8;
  localparam int NPIX = TH * TV;

  logic        video_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [11:0] pixel_rgb = '0;
  logic [9:0]  marker_x = 10'd1023;
  logic [8:0]  marker_y = '0;
  logic        bram_we;
  logic [18:0] bram_addr;
  logic [2:0]  bram_din;
  logic        frame_written;
  logic        short_frame;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 video_clk = ~video_clk;

  color_label_writer #(
    .H_ACTIVE (TH),
    .V_ACTIVE (TV)
  ) dut (
    .video_clk     (video_clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .frame_start   (frame_start),
    .pixel_valid   (pixel_valid),
    .pixel_rgb     (pixel_rgb),
    .marker_x      (marker_x),
    .marker_y      (marker_y),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .frame_written (frame_written),
    .short_frame   (short_frame),
    .overrun       (overrun)
  );

  // Write monitor: cleared by DUT reset, records the label buffer and event counts.
  int          cyc = 0;
  int          wr_cnt, order_err, fw_cnt, fw_bad, sf_cnt, zero_cyc;
  logic [18:0] prev_addr;
  logic [2:0]  mem [NPIX];

  always @(posedge video_clk) cyc++;

  always @(negedge video_clk) begin
    if (!reset_n) begin
      wr_cnt = 0; order_err = 0; fw_cnt = 0; fw_bad = 0; sf_cnt = 0;
      zero_cyc = -1; prev_addr = '0;
    end else begin
      if (bram_we) begin
        if (bram_addr != 19'd0 && bram_addr != prev_addr + 19'd1) order_err++;
        if (bram_addr == 19'd0) zero_cyc = cyc;
        prev_addr = bram_addr;
        wr_cnt++;
        if (int'(bram_addr) < NPIX) mem[bram_addr] = bram_din;
      end
      if (frame_written) begin
        fw_cnt++;
        if (!bram_we || bram_addr != 19'(NPIX - 1)) fw_bad++;
      end
      if (short_frame) sf_cnt++;
    end
  end

  logic [11:0] stim    [NPIX];
  logic [2:0]  exp_lbl [NPIX];
  int          base_wr, base_fw, base_sf, t0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge video_clk);
    #1;
  endtask

  task automatic idle(input int n);
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic fill(input logic [11:0] rgb, input logic [2:0] lbl);
    for (int i = 0; i < NPIX; i++) begin
      stim[i]    = rgb;
      exp_lbl[i] = lbl;
    end
  endtask

  task automatic run_pixels(input int n, input bit fs);
    for (int i = 0; i < n; i++) begin
      frame_start = fs && (i == 0);
      pixel_valid = 1'b1;
      pixel_rgb   = stim[i];
      tick();
    end
    frame_start = 1'b0;
    pixel_valid = 1'b0;
  endtask

  function automatic int count_bad();
    int b = 0;
    for (int a = 0; a < NPIX; a++) if (mem[a] !== exp_lbl[a]) b++;
    return b;
  endfunction

  function automatic int count_val(input logic [2:0] v);
    int c = 0;
    for (int a = 0; a < NPIX; a++) if (mem[a] === v) c++;
    return c;
  endfunction

  task automatic snap();
    base_wr = wr_cnt;
    base_fw = fw_cnt;
    base_sf = sf_cnt;
  endtask

  initial begin
    repeat (3) tick();
    @(negedge video_clk);
    check_eq("rst_we", int'(bram_we), 0);
    check_eq("rst_addr", int'(bram_addr), 0);
    check_eq("rst_din", int'(bram_din), 0);
    check_eq("rst_fw", int'(frame_written), 0);
    check_eq("rst_short", int'(short_frame), 0);
    check_eq("rst_overrun", int'(overrun), 0);
    reset_n = 1'b1;
    tick();

    // Full red frame: count, order, single frame_written, 3-cycle latency.
    enable = 1'b1;
    fill(12'hF00, 3'd1);
    t0 = cyc;
    run_pixels(NPIX, 1'b1);
    idle(6);
    check_eq("red_writes", wr_cnt, NPIX);
    check_eq("red_order", order_err, 0);
    check_eq("red_fw_count", fw_cnt, 1);
    check_eq("red_fw_on_last", fw_bad, 0);
    check_eq("red_latency", zero_cyc - t0, 3);
    check_eq("red_labels_bad", count_bad(), 0);
    check_eq("red_overrun", int'(overrun), 0);
    check_eq("red_short", sf_cnt, 0);

    // Class patterns plus threshold boundaries, started straight from DONE.
    fill(12'h000, 3'd0);
    stim[0] = 12'h0F0;  exp_lbl[0] = 3'd2;
    stim[1] = 12'h00F;  exp_lbl[1] = 3'd3;
    stim[2] = 12'hF0F;  exp_lbl[2] = 3'd4;
    stim[3] = 12'h0FF;  exp_lbl[3] = 3'd5;
    stim[4] = 12'hFF0;  exp_lbl[4] = 3'd7;
    stim[5] = 12'h888;  exp_lbl[5] = 3'd0;
    stim[6] = 12'h000;  exp_lbl[6] = 3'd0;
    stim[7] = 12'h800;  exp_lbl[7] = 3'd1;
    stim[8] = 12'h700;  exp_lbl[8] = 3'd0;
    stim[9] = 12'h850;  exp_lbl[9] = 3'd1;
    stim[10] = 12'h860; exp_lbl[10] = 3'd0;
    snap();
    run_pixels(NPIX, 1'b1);
    idle(6);
    for (int i = 0; i <= 10; i++) begin
      check_eq($sformatf("class_px%0d", i), int'(mem[i]), int'(exp_lbl[i]));
    end
    check_eq("class_rest_bad", count_bad(), 0);
    check_eq("class_writes", wr_cnt - base_wr, NPIX);
    check_eq("class_fw", fw_cnt - base_fw, 1);

    // Crosshair at column 100 / row 5, then disabled by an out-of-range column.
    marker_x = 10'd100;
    marker_y = 9'd5;
    fill(12'h000, 3'd0);
    for (int a = 0; a < NPIX; a++) begin
      if ((a % TH) == 100 || (a / TH) == 5) exp_lbl[a] = 3'd6;
    end
    run_pixels(NPIX, 1'b1);
    idle(6);
    check_eq("marker_bad", count_bad(), 0);
    check_eq("marker_count", count_val(3'd6), TV + TH - 1);
    marker_x = 10'd700;
    run_pixels(NPIX, 1'b1);
    idle(6);
    check_eq("marker_off_count", count_val(3'd6), 0);
    check_eq("marker_off_zero", count_val(3'd0), NPIX);
    check_eq("marker_order", order_err, 0);

    // Short frame: restart after 1000 red pixels with a green frame.
    fill(12'hF00, 3'd1);
    snap();
    run_pixels(1000, 1'b1);
    fill(12'h0F0, 3'd2);
    t0 = cyc;
    run_pixels(NPIX, 1'b1);
    idle(6);
    check_eq("short_pulses", sf_cnt - base_sf, 1);
    check_eq("short_latency", zero_cyc - t0, 3);
    check_eq("short_writes", wr_cnt - base_wr, 1000 + NPIX);
    check_eq("short_fw", fw_cnt - base_fw, 1);
    check_eq("short_labels_bad", count_bad(), 0);
    check_eq("short_order", order_err, 0);
    check_eq("short_overrun", int'(overrun), 0);

    // Overrun: extra pixels after a complete frame are dropped and latch overrun.
    snap();
    run_pixels(5, 1'b0);
    idle(6);
    check_eq("ovr_writes", wr_cnt - base_wr, 0);
    check_eq("ovr_flag", int'(overrun), 1);
    run_pixels(NPIX, 1'b1);
    idle(6);
    check_eq("ovr_sticky", int'(overrun), 1);
    check_eq("ovr_next_writes", wr_cnt - base_wr, NPIX);

    // enable only takes effect at frame_start.
    enable = 1'b0;
    fill(12'h00F, 3'd3);
    snap();
    run_pixels(100, 1'b1);
    enable = 1'b1;
    run_pixels(100, 1'b0);
    idle(6);
    check_eq("en_off_writes", wr_cnt - base_wr, 0);
    check_eq("en_off_overrun", int'(overrun), 1);

    // Mid-frame reset with the pixel stream still running.
    snap();
    run_pixels(2000, 1'b1);
    check_eq("pre_rst_writes", wr_cnt - base_wr, 1997);
    pixel_valid = 1'b1;
    reset_n = 1'b0;
    tick();
    @(negedge video_clk);
    check_eq("mid_rst_we", int'(bram_we), 0);
    check_eq("mid_rst_addr", int'(bram_addr), 0);
    check_eq("mid_rst_din", int'(bram_din), 0);
    check_eq("mid_rst_fw", int'(frame_written), 0);
    check_eq("mid_rst_short", int'(short_frame), 0);
    check_eq("mid_rst_overrun", int'(overrun), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge video_clk);
      check_eq($sformatf("mid_rst_we_c%0d", i), int'(bram_we), 0);
    end
    tick();
    reset_n = 1'b1;
    repeat (20) tick();
    pixel_valid = 1'b0;
    idle(4);
    check_eq("post_rst_writes", wr_cnt, 0);
    check_eq("post_rst_overrun", int'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
